// File: rtl/serial_magnitude_comparator_if.sv
// Request/response bundle for the bit-serial comparator; the master issues start/operands,
// the slave (comparator) returns busy/done, the decision flags and the result.
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 5
);
   localparam int IDXW = $clog2(WIDTH);

   logic             start;
   logic [2:0]       mode;
   logic             signed_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;

   logic             busy;
   logic             done;
   logic             result;
   logic             lt;
   logic             eq;
   logic             gt;
   logic [IDXW-1:0]  diff_pos;
   logic             mode_err;

   modport master (
      output start, mode, signed_mode, a, b,
      input  busy, done, result, lt, eq, gt, diff_pos, mode_err
   );

   modport slave (
      input  start, mode, signed_mode, a, b,
      output busy, done, result, lt, eq, gt, diff_pos, mode_err
   );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first bit-serial EQ/NE/LT/GT/LE/GE comparator; done 2..WIDTH+1 cycles after start.
// start is accepted only in IDLE or the DONE cycle; starts while busy are dropped.
module serial_magnitude_comparator #(
   parameter int WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   serial_magnitude_comparator_if.slave  cmp
);
   localparam int IDXW = $clog2(WIDTH);
   localparam logic [IDXW-1:0] MSB_IDX = IDXW'(WIDTH - 1);

   localparam logic [2:0] MODE_EQ = 3'b000;
   localparam logic [2:0] MODE_NE = 3'b001;
   localparam logic [2:0] MODE_LT = 3'b010;
   localparam logic [2:0] MODE_GT = 3'b011;
   localparam logic [2:0] MODE_LE = 3'b100;
   localparam logic [2:0] MODE_GE = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_mode;
   logic             r_signed;
   logic [IDXW-1:0]  r_idx;

   logic             r_busy;
   logic             r_done;
   logic             r_result;
   logic             r_lt;
   logic             r_eq;
   logic             r_gt;
   logic [IDXW-1:0]  r_diff_pos;
   logic             r_mode_err;

   logic             w_bit_a;
   logic             w_bit_b;
   logic             w_bit_diff;
   logic             w_last;
   logic             w_sign_inv;
   logic             w_finish;
   logic             w_lt_nxt;
   logic             w_eq_nxt;
   logic             w_gt_nxt;
   logic             w_result_nxt;
   logic             w_mode_err;

   assign w_bit_a    = r_a[r_idx];
   assign w_bit_b    = r_b[r_idx];
   assign w_bit_diff = w_bit_a ^ w_bit_b;
   assign w_last     = (r_idx == '0);
   assign w_finish   = w_bit_diff | w_last;

   // In two's complement a set sign bit means the smaller value, so the MSB decision flips.
   assign w_sign_inv = r_signed & (r_idx == MSB_IDX);
   assign w_gt_nxt   = w_bit_diff & (w_bit_a ^ w_sign_inv);
   assign w_lt_nxt   = w_bit_diff & (w_bit_b ^ w_sign_inv);
   assign w_eq_nxt   = ~w_bit_diff;
   assign w_mode_err = &r_mode[2:1];

   always_comb begin
      w_result_nxt = 1'b0;
      case (r_mode)
         MODE_EQ: w_result_nxt = w_eq_nxt;
         MODE_NE: w_result_nxt = ~w_eq_nxt;
         MODE_LT: w_result_nxt = w_lt_nxt;
         MODE_GT: w_result_nxt = w_gt_nxt;
         MODE_LE: w_result_nxt = w_lt_nxt | w_eq_nxt;
         MODE_GE: w_result_nxt = w_gt_nxt | w_eq_nxt;
         default: w_result_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_mode     <= '0;
         r_signed   <= 1'b0;
         r_idx      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= 1'b0;
         r_lt       <= 1'b0;
         r_eq       <= 1'b1;
         r_gt       <= 1'b0;
         r_diff_pos <= '0;
         r_mode_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (cmp.start) begin
                  r_a      <= cmp.a;
                  r_b      <= cmp.b;
                  r_mode   <= cmp.mode;
                  r_signed <= cmp.signed_mode;
                  r_idx    <= MSB_IDX;
                  r_busy   <= 1'b1;
                  r_state  <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_finish) begin
                  r_state    <= S_DONE;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_lt       <= w_lt_nxt;
                  r_eq       <= w_eq_nxt;
                  r_gt       <= w_gt_nxt;
                  r_diff_pos <= w_bit_diff ? r_idx : '0;
                  r_result   <= w_result_nxt;
                  r_mode_err <= w_mode_err;
               end else begin
                  r_idx <= r_idx - IDXW'(1);
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
               if (cmp.start) begin
                  r_a      <= cmp.a;
                  r_b      <= cmp.b;
                  r_mode   <= cmp.mode;
                  r_signed <= cmp.signed_mode;
                  r_idx    <= MSB_IDX;
                  r_busy   <= 1'b1;
                  r_state  <= S_SCAN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign cmp.busy     = r_busy;
   assign cmp.done     = r_done;
   assign cmp.result   = r_result;
   assign cmp.lt       = r_lt;
   assign cmp.eq       = r_eq;
   assign cmp.gt       = r_gt;
   assign cmp.diff_pos = r_diff_pos;
   assign cmp.mode_err = r_mode_err;
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Parametrised, bit-serial, multi-mode comparator for two WIDTH-bit operands. It supersedes the fixed 5-bit combinational inequality check and evaluates EQ, NE, LT, GT, LE and GE in unsigned or two's-complement form. Operands are scanned MSB-first, one bit per clock, and the scan stops at the first differing bit. A start/busy/done handshake lets a sequencing controller in the ALU datapath drive it.

Parameters:
WIDTH, 5, operand width in bits; legal range 2..32.
IDXW, $clog2(WIDTH), width of diff_pos; derived, not overridden.

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; accepted only while busy=0
mode  input  3  comparison select: 000 EQ, 001 NE, 010 LT, 011 GT, 100 LE, 101 GE, 110/111 reserved
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
a  input  WIDTH  first operand
b  input  WIDTH  second operand
busy  output  1  high while in SCAN
done  output  1  one-cycle pulse: result and flags are updated this cycle
result  output  1  boolean outcome of the selected mode
lt  output  1  a < b under the captured signedness
eq  output  1  a == b
gt  output  1  a > b under the captured signedness
diff_pos  output  IDXW  index of the most-significant differing bit; 0 when equal
mode_err  output  1  captured mode was reserved

Behaviour:
- Reset (rst_n=0, any time, including mid-scan): state goes to IDLE immediately. busy, done, result, lt, gt, diff_pos and mode_err go to 0. eq goes to 1. Captured operand registers are cleared.
- States: IDLE, SCAN, DONE.
- IDLE with start=1: capture a, b, mode and signed_mode; set idx=WIDTH-1; go to SCAN. Inputs are not sampled again until the next accepted start.
- SCAN, one cycle per bit: examine a_q[idx] against b_q[idx].
  - Bits differ: record the decision, set diff_pos=idx, go to DONE.
  - Bits equal and idx==0: record equal, go to DONE.
  - Otherwise: idx decrements by 1 and the state stays in SCAN.
- Decision rule when bits differ:
  - Unsigned, or idx < WIDTH-1: gt = a_q[idx], lt = b_q[idx].
  - signed_mode=1 and idx==WIDTH-1 (sign bit): sense is inverted, so gt = b_q[idx] and lt = a_q[idx].
- Flags: exactly one of lt, eq, gt is 1 after any completed compare.
- DONE lasts one cycle:
  - done=1 and busy=0.
  - result = f(mode, lt, eq, gt) per the mode table above.
  - Reserved mode: result=0 and mode_err=1; otherwise mode_err=0.
  - Next state is IDLE, or SCAN if start=1 in this cycle (back-to-back accept).
- Latency: with start accepted at edge 0, done is high in the cycle after edge k+1, where k = WIDTH-1-(index of first differing bit).
  - Best case (MSB differs): 2 cycles.
  - Worst case (operands equal): WIDTH+1 cycles.
- Holding: result, lt, eq, gt, diff_pos and mode_err are registered. They change only in DONE and hold until the next DONE or reset.
- start while busy=1: ignored, with no effect on the captured operands.
- Input changes on a, b, mode or signed_mode during SCAN: no effect on the outcome.

Test Plan:
1. WIDTH=5, unsigned, mode=NE, a=10101, b=10101 → done 6 cycles after start; result=0, eq=1, diff_pos=0.
2. WIDTH=5, unsigned, mode=NE, a=11111, b=00000 → done 2 cycles after start; result=1, gt=1, diff_pos=4.
3. WIDTH=5, signed_mode=1, mode=LT, a=11111 (-1), b=00001 (+1) → done at 2 cycles; lt=1, result=1. The same operands with signed_mode=0 give gt=1, result=0.
4. WIDTH=5, mode=GE, a=11010, b=11011 → done at 6 cycles; lt=1, diff_pos=0, result=0.
   - Pulse start again mid-scan with different operands → ignored; outcome unchanged.
5. Back-to-back requests: assert start in the DONE cycle with mode=110 → a new scan begins next cycle; its done gives mode_err=1, result=0.
6. Reset mid-scan: drop rst_n during SCAN of a compare that differs only at bit 0 → busy=0 and eq=1 immediately, and no done pulse.
   - Separately, rerun tests 1–2 with WIDTH=8 and WIDTH=2: worst-case latency is WIDTH+1 cycles.
